uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Receive-side buffer placed directly downstream of `uart_rx`. It captures each byte that `uart_rx` presents on its `receive_data`/`ready` outputs and stores it in a small circular FIFO. It then hands the bytes to the consumer over a valid/ready handshake, so a slow consumer does not lose characters. Overflow is detected, flagged and, optionally, counted.

## Interface
- `DATA_WIDTH`, 8, byte width; must match `uart_rx`.
- `DEPTH_LOG2`, 4, log2 of FIFO depth (depth = 2^DEPTH_LOG2, ≥ 2).
- `clk` in 1: system clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `rx_data` in DATA_WIDTH: byte from `uart_rx.receive_data`.
- `rx_ready` in 1: `uart_rx.ready`. Treated as a level; only its rising edge is a new byte.
- `out_data` out DATA_WIDTH: head-of-FIFO byte, first-word-fall-through.
- `out_valid` out 1: FIFO non-empty.
- `out_ready` in 1: consumer accepts `out_data` this cycle.
- `level` out DEPTH_LOG2+1: current occupancy, 0..2^DEPTH_LOG2.
- `full` out 1: `level` == depth.
- `overflow` out 1: sticky flag set when a byte was dropped.
- `clr_ovf` in 1: synchronous clear of `overflow` (and `drop_count`).
- `drop_count` out 8: saturating count of dropped bytes.

## Operation
- Edge detect: register `rx_ready_q`. The push condition is `rx_ready & ~rx_ready_q`. `rx_data` is sampled in that same cycle.
- Pop condition is `out_valid & out_ready`.
- Storage: 2^DEPTH_LOG2 × DATA_WIDTH array.
  - Write pointer and read pointer are DEPTH_LOG2 bits each and wrap naturally from max to 0.
  - `level` is kept as a separate counter.
- Per-cycle cases, by (push, pop):
  - (0,0): hold.
  - (1,0), not full: write at wr_ptr, wr_ptr+1, level+1.
  - (1,0), full: byte dropped; pointers and level unchanged; overflow event.
  - (0,1): rd_ptr+1, level−1.
  - (1,1): both act and level is unchanged. This includes the full case: the pop frees the slot, so the push is accepted and there is no overflow.
- A pop is impossible when empty, because `out_valid`=0. A push into an empty FIFO is therefore never popped in the same cycle.
- `out_data` = mem[rd_ptr], combinational from the array. Its value is don't-care when `out_valid`=0.
- Overflow event: `overflow` ← 1.
- `clr_ovf`=1: `overflow` ← 0 and `drop_count` ← 0. If `clr_ovf` and an overflow event occur in the same cycle, the set wins: `overflow`=1 and `drop_count`=1.
- `clr_ovf` has no effect on FIFO contents.

## Timing
- Reset values:
  - `out_valid`=0, `level`=0, `full`=0, `overflow`=0, `drop_count`=0, pointers=0.
  - `rx_ready_q`=1, so an `rx_ready` held high through reset is not a byte.
  - Array contents are not reset.
- Reset asserted mid-operation empties the FIFO immediately and discards all stored bytes.
- Latency from push edge to visible output: the byte is written on the clock edge where push is high. `out_valid` rises and `out_data` shows the byte in the following cycle.
- Pop: `out_data` advances to the next entry in the cycle after the accepting edge.
- Back-to-back pops sustain 1 byte/cycle. Push rate is limited by `uart_rx`: at most one rising edge per 2 cycles.
- `full`, `out_valid` and `level` are derived from registered state only. None of them depends combinationally on `out_ready` or `rx_ready`.

## Configuration
- `UART_RX_FIFO_DROP_CNT_EN` defined: `drop_count` increments on each overflow event and saturates at 255.
- Not defined: the `drop_count` port remains and is tied to 0, and its counter logic is not generated. The `overflow` flag behaves identically in both builds.

## Test plan
All scenarios use DEPTH_LOG2=2 (depth 4).
- Reset with `rx_ready`=1 held, then release → no push; `level`=0 and `out_valid`=0 in every cycle.
- Four rising edges with 0x41, 0x42, 0x43, 0x44, `out_ready`=0 → `level`=4, `full`=1, `out_data`=0x41. Then assert `out_ready` for 4 cycles → outputs 0x41..0x44 in order, then `out_valid`=0 and `level`=0.
- FIFO full, fifth edge with 0x55, no pop → byte dropped, `overflow`=1, `drop_count`=1 (0 when the macro is undefined). Contents still 0x41..0x44. Then `clr_ovf` pulse → `overflow`=0, `drop_count`=0.
- FIFO full, push 0x66 in the same cycle as a pop → no overflow, `level` stays 4. Draining yields 0x42, 0x43, 0x44, 0x66.
- Wrap-around: 10 alternating push/pop pairs with bytes 0x00..0x09 → output sequence 0x00..0x09 with no loss, and `level` never exceeds 1.
- Assert `rst_n`=0 while `level`=3 → `level`=0 and `out_valid`=0 immediately, without waiting for a clock. A subsequent push of 0x7E is read back as the first byte.

Source files
------------

// File: rtl/uart_rx_fifo_if.sv
// Bus bundle between uart_rx_fifo and its environment: byte capture side, FWFT consumer side,
// occupancy and overflow status. The master drives the inputs of the FIFO, the slave is the FIFO.
interface uart_rx_fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH_LOG2 = 4
);
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DEPTH_LOG2:0]   level;
    logic                  full;
    logic                  overflow;
    logic                  clr_ovf;
    logic [7:0]            drop_count;

    modport master (
        output rx_data,
        output rx_ready,
        output out_ready,
        output clr_ovf,
        input  out_data,
        input  out_valid,
        input  level,
        input  full,
        input  overflow,
        input  drop_count
    );

    modport slave (
        input  rx_data,
        input  rx_ready,
        input  out_ready,
        input  clr_ovf,
        output out_data,
        output out_valid,
        output level,
        output full,
        output overflow,
        output drop_count
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: captures each rising edge of uart_rx.ready into a first-word-fall-through circular FIFO.
// Define UART_RX_FIFO_DROP_CNT_EN to build the saturating drop counter; otherwise drop_count reads 0.
module uart_rx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input logic           clk,
    input logic           rst_n,
    uart_rx_fifo_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] L_FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wrPtr;
    logic [DEPTH_LOG2-1:0] r_rdPtr;
    logic [DEPTH_LOG2:0]   r_level;
    logic                  r_rxReadyQ;
    logic                  r_overflow;

    logic w_push;
    logic w_pop;
    logic w_full;
    logic w_outValid;
    logic w_write;
    logic w_ovfEvent;

    assign w_full     = (r_level == L_FULL_LEVEL);
    assign w_outValid = (r_level != '0);
    assign w_push     = bus.rx_ready & ~r_rxReadyQ;
    assign w_pop      = w_outValid & bus.out_ready;
    // A simultaneous pop frees the slot, so a push into a full FIFO is only dropped without a pop.
    assign w_write    = w_push & (~w_full | w_pop);
    assign w_ovfEvent = w_push & w_full & ~w_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rxReadyQ <= 1'b1;
        end else begin
            r_rxReadyQ <= bus.rx_ready;
        end
    end

    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[r_wrPtr] <= bus.rx_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_write) begin
                r_wrPtr <= r_wrPtr + DEPTH_LOG2'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + DEPTH_LOG2'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level <= '0;
        end else begin
            case ({w_write, w_pop})
                2'b10:   r_level <= r_level + (DEPTH_LOG2 + 1)'(1);
                2'b01:   r_level <= r_level - (DEPTH_LOG2 + 1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (w_ovfEvent) begin
            r_overflow <= 1'b1;
        end else if (bus.clr_ovf) begin
            r_overflow <= 1'b0;
        end
    end

`ifdef UART_RX_FIFO_DROP_CNT_EN
    logic [7:0] r_dropCount;

    // A drop in the same cycle as a clear restarts the count at one rather than zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dropCount <= '0;
        end else if (w_ovfEvent) begin
            if (bus.clr_ovf) begin
                r_dropCount <= 8'd1;
            end else if (r_dropCount != 8'hFF) begin
                r_dropCount <= r_dropCount + 8'd1;
            end
        end else if (bus.clr_ovf) begin
            r_dropCount <= '0;
        end
    end

    assign bus.drop_count = r_dropCount;
`else
    assign bus.drop_count = '0;
`endif

    assign bus.out_data  = r_mem[r_rdPtr];
    assign bus.out_valid = w_outValid;
    assign bus.level     = r_level;
    assign bus.full      = w_full;
    assign bus.overflow  = r_overflow;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo (depth 4): directed scenarios followed by random traffic,
// all compared against a queue-based reference model of the FIFO behaviour.
module tb_uart_rx_fifo;
    localparam int DW    = 8;
    localparam int DL    = 2;
    localparam int DEPTH = 4;
`ifdef UART_RX_FIFO_DROP_CNT_EN
    localparam int EXP_DROP1 = 1;
`else
    localparam int EXP_DROP1 = 0;
`endif

    logic clk;
    logic rst_n;

    uart_rx_fifo_if #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL)) bus ();

    uart_rx_fifo #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] mQ[$];
    bit         mOvf;
    int         mDrop;
    bit         mPrevRx;
    logic [7:0] dutLog[$];
    int         maxLevel;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        mQ.delete();
        mOvf    = 1'b0;
        mDrop   = 0;
        mPrevRx = 1'b1;
    endtask

    task automatic compareAll();
        checkOutput("level", 32'(bus.level), mQ.size());
        checkOutput("outValid", 32'(bus.out_valid), (mQ.size() != 0) ? 1 : 0);
        checkOutput("full", 32'(bus.full), (mQ.size() == DEPTH) ? 1 : 0);
        checkOutput("overflow", 32'(bus.overflow), 32'(mOvf));
        checkOutput("dropCount", 32'(bus.drop_count), mDrop);
        if (mQ.size() != 0) begin
            checkOutput("outData", 32'(bus.out_data), 32'(mQ[0]));
        end
    endtask

    // One clock: check the present state, drive inputs at negedge, then advance the model at posedge.
    task automatic applyStimulus(input bit rxReady, input logic [7:0] rxData, input bit outReady, input bit clrOvf);
        bit push;
        bit pop;
        bit wasFull;
        bit evt;
        logic [7:0] discard;
        @(negedge clk);
        compareAll();
        if (32'(bus.level) > maxLevel) maxLevel = 32'(bus.level);
        bus.rx_ready  = rxReady;
        bus.rx_data   = rxData;
        bus.out_ready = outReady;
        bus.clr_ovf   = clrOvf;
        push = rxReady && !mPrevRx;
        pop  = (mQ.size() != 0) && outReady;
        if (bus.out_valid && outReady) dutLog.push_back(bus.out_data);
        @(posedge clk);
        wasFull = (mQ.size() == DEPTH);
        evt = 1'b0;
        if (pop) discard = mQ.pop_front();
        if (push) begin
            if (!wasFull || pop) mQ.push_back(rxData);
            else evt = 1'b1;
        end
        mPrevRx = rxReady;
        if (evt) mOvf = 1'b1;
        else if (clrOvf) mOvf = 1'b0;
`ifdef UART_RX_FIFO_DROP_CNT_EN
        if (evt) mDrop = clrOvf ? 1 : ((mDrop + 1 > 255) ? 255 : mDrop + 1);
        else if (clrOvf) mDrop = 0;
`endif
        #1;
    endtask

    task automatic pushByte(input logic [7:0] data, input bit outReady);
        applyStimulus(1'b0, data, outReady, 1'b0);
        applyStimulus(1'b1, data, outReady, 1'b0);
    endtask

    task automatic checkLog(input string tag, input logic [7:0] expSeq[$]);
        checkOutput({tag, "Count"}, dutLog.size(), expSeq.size());
        for (int i = 0; i < expSeq.size() && i < dutLog.size(); i++) begin
            checkOutput($sformatf("%s%0d", tag, i), 32'(dutLog[i]), 32'(expSeq[i]));
        end
    endtask

    initial begin
        logic [7:0] expSeq[$];

        bus.rx_ready  = 1'b1;
        bus.rx_data   = 8'h00;
        bus.out_ready = 1'b0;
        bus.clr_ovf   = 1'b0;
        rst_n         = 1'b0;
        modelReset();
        maxLevel = 0;

        // Reset with rx_ready held high, then keep it high after release: never a push.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("rstLevel", 32'(bus.level), 0);
            checkOutput("rstValid", 32'(bus.out_valid), 0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0);
        checkOutput("heldHighLevel", 32'(bus.level), 0);

        // Fill with four bytes, then drain in order.
        for (int i = 0; i < 4; i++) pushByte(8'h41 + 8'(i), 1'b0);
        checkOutput("fillLevel", 32'(bus.level), 4);
        checkOutput("fillFull", 32'(bus.full), 1);
        checkOutput("fillHead", 32'(bus.out_data), 32'h41);
        dutLog.delete();
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        expSeq = '{8'h41, 8'h42, 8'h43, 8'h44};
        checkLog("drainA", expSeq);
        checkOutput("drainValid", 32'(bus.out_valid), 0);
        checkOutput("drainLevel", 32'(bus.level), 0);

        // Overflow on a fifth byte, then clear.
        for (int i = 0; i < 4; i++) pushByte(8'h41 + 8'(i), 1'b0);
        pushByte(8'h55, 1'b0);
        checkOutput("ovfFlag", 32'(bus.overflow), 1);
        checkOutput("ovfDrop", 32'(bus.drop_count), EXP_DROP1);
        checkOutput("ovfLevel", 32'(bus.level), 4);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("clrFlag", 32'(bus.overflow), 0);
        checkOutput("clrDrop", 32'(bus.drop_count), 0);

        // Full FIFO: push 0x66 in the same cycle as a pop.
        dutLog.delete();
        applyStimulus(1'b1, 8'h66, 1'b1, 1'b0);
        checkOutput("simulLevel", 32'(bus.level), 4);
        checkOutput("simulOvf", 32'(bus.overflow), 0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        expSeq = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h66};
        checkLog("drainB", expSeq);

        // Wrap-around with alternating push/pop.
        dutLog.delete();
        maxLevel = 0;
        for (int i = 0; i < 10; i++) pushByte(8'(i), 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        expSeq = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
        checkLog("wrap", expSeq);
        checkOutput("wrapMaxLevel", (maxLevel <= 1) ? 1 : 0, 1);

        // Asynchronous reset with three bytes stored.
        for (int i = 0; i < 3; i++) pushByte(8'hC0 + 8'(i), 1'b0);
        checkOutput("preRstLevel", 32'(bus.level), 3);
        #2;
        rst_n = 1'b0;
        bus.rx_ready = 1'b0;
        #1;
        checkOutput("asyncRstLevel", 32'(bus.level), 0);
        checkOutput("asyncRstValid", 32'(bus.out_valid), 0);
        modelReset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        dutLog.delete();
        pushByte(8'h7E, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("postRstFirst", (dutLog.size() != 0) ? 32'(dutLog[0]) : 32'hFFFF_FFFF, 32'h7E);

        // Long overflow burst to exercise drop counter saturation, then clear and drain.
        for (int i = 0; i < 300; i++) pushByte(8'($urandom_range(0, 255)), 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                          ($urandom_range(0, 3) == 0), ($urandom_range(0, 40) == 0));
        end
        for (int i = 0; i < 800; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                          ($urandom_range(0, 3) != 0), ($urandom_range(0, 60) == 0));
        end
        @(negedge clk);
        compareAll();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
